// File: rtl/exec_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// mips_muldiv_pkg
// Shared definitions for the Execute-stage multiply/divide unit:
//   - operation encodings presented on the op port
//   - FSM state type
//   - divider iteration count
//   - small helper that classifies an operation as signed
// ----------------------------------------------------------------------------
package mips_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_SIGN = 3'd3,
    ST_DONE = 3'd4
  } md_state_t;

  // op[0] clear means the signed flavour (MULT / DIV)
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/exec_muldiv_div_iter.sv
// ----------------------------------------------------------------------------
// div_iter
// Unsigned radix-2 restoring divider core, one quotient bit per step.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   load                 capture dividend/divisor and clear the remainder
//   dividend, divisor    unsigned operands (sampled on load)
//   step                 perform one restoring iteration
//   quotient, remainder  running results; final after WIDTH steps
// The quotient register doubles as the dividend shift register: each step
// shifts its MSB into the partial remainder and its freed LSB receives the
// new quotient bit. A zero divisor yields garbage here; the caller overrides.
// ----------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   diff_s;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, dvsr_r};
  end

  // Divider state: load operands or perform one restoring iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r  <= {WIDTH{1'b0}};
      quo_r  <= {WIDTH{1'b0}};
      dvsr_r <= {WIDTH{1'b0}};
    end else if (load) begin
      rem_r  <= {WIDTH{1'b0}};
      quo_r  <= dividend;
      dvsr_r <= divisor;
    end else if (step) begin
      if (!diff_s[WIDTH]) begin
        // subtraction fits: keep the difference, quotient bit is 1
        rem_r <= diff_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
      end else begin
        // restore: partial remainder is below the divisor, so it fits WIDTH bits
        rem_r <= shift_s[WIDTH-1:0];
        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_r  <= rem_r;
      quo_r  <= quo_r;
      dvsr_r <= dvsr_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/exec_muldiv.sv
// ----------------------------------------------------------------------------
// exec_muldiv
// Multi-cycle multiply/divide unit of the Execute stage. Produces the HI/LO
// pair for MULT, MULTU, DIV and DIVU.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   start          request an operation (accepted in IDLE or DONE)
//   op             00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b   rs / rt operands
//   flush          abort any operation, return to IDLE
//   stall          hold Execute and earlier stages
//   busy           operation in flight (MUL, DIV or SIGN)
//   done           one-cycle pulse, hi/lo valid
//   hi, lo         upper product / remainder, lower product / quotient
// Latency from acceptance at cycle t: MUL done at t+1+MUL_LATENCY,
// DIV done at t+34 (32 iterations, one SIGN cycle, then DONE).
// ----------------------------------------------------------------------------
module exec_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_LATENCY - 1);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

  md_state_t        state_r;
  logic [5:0]       cnt_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             done_r;
  logic             busy_r;

  logic             accept_s;
  logic             in_flight_s;
  logic             step_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
  logic             neg_q_s;
  logic             neg_r_s;
  logic [2*WIDTH-1:0] ext_a_s;
  logic [2*WIDTH-1:0] ext_b_s;
  logic [2*WIDTH-1:0] prod_s;

  // Acceptance, stall and divider stepping decode from the current state
  always_comb begin
    in_flight_s = (state_r == ST_MUL) || (state_r == ST_DIV) || (state_r == ST_SIGN);
    accept_s    = start && !flush && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    step_s      = (state_r == ST_DIV);
  end

  assign stall = accept_s | in_flight_s;

  // Operand magnitudes handed to the unsigned divider core at acceptance
  always_comb begin
    a_mag_s = src_a;
    b_mag_s = src_b;
    if (is_signed_op(op) && src_a[WIDTH-1]) begin
      a_mag_s = -src_a;
    end else begin
      a_mag_s = src_a;
    end
    if (is_signed_op(op) && src_b[WIDTH-1]) begin
      b_mag_s = -src_b;
    end else begin
      b_mag_s = src_b;
    end
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .step      (step_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Full-width product: sign- or zero-extend to 2*WIDTH, keep the low 2*WIDTH bits
  always_comb begin
    ext_a_s = {{WIDTH{a_r[WIDTH-1] & is_signed_op(op_r)}}, a_r};
    ext_b_s = {{WIDTH{b_r[WIDTH-1] & is_signed_op(op_r)}}, b_r};
    prod_s  = ext_a_s * ext_b_s;
  end

  // Sign fixup of the divider result; divide by zero bypasses the fixup
  always_comb begin
    neg_q_s = (op_r == MD_DIV) && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
    neg_r_s = (op_r == MD_DIV) && a_r[WIDTH-1];
    q_fix_s = quo_s;
    r_fix_s = rem_s;
    if (b_r == {WIDTH{1'b0}}) begin
      q_fix_s = {WIDTH{1'b1}};
      r_fix_s = a_r;
    end else begin
      if (neg_q_s) begin
        q_fix_s = -quo_s;
      end else begin
        q_fix_s = quo_s;
      end
      if (neg_r_s) begin
        r_fix_s = -rem_s;
      end else begin
        r_fix_s = rem_s;
      end
    end
  end

  // Control FSM with registered done/busy and the HI/LO result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      op_r    <= 2'b00;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else if (flush) begin
      // abort: results keep their previous values, no done follows
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r    <= op;
            a_r     <= src_a;
            b_r     <= src_b;
            cnt_r   <= 6'd0;
            busy_r  <= 1'b1;
            state_r <= op[1] ? ST_DIV : ST_MUL;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == MUL_LAST) begin
            hi_r    <= prod_s[2*WIDTH-1:WIDTH];
            lo_r    <= prod_s[WIDTH-1:0];
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + 6'd1;
          end
        end
        ST_DIV: begin
          if (cnt_r == DIV_LAST) begin
            state_r <= ST_SIGN;
          end else begin
            cnt_r   <= cnt_r + 6'd1;
          end
        end
        ST_SIGN: begin
          hi_r    <= r_fix_s;
          lo_r    <= q_fix_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_DONE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_exec_muldiv.sv
// ----------------------------------------------------------------------------
// tb_exec_muldiv
// Directed and randomized checks of exec_muldiv against an arithmetic
// reference model (native 64-bit signed/unsigned multiply, divide, modulo).
// A second instance with MUL_LATENCY=3 covers the longer multiply.
// ----------------------------------------------------------------------------
module tb_exec_muldiv;
  import mips_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  logic        start3;
  logic        flush3;
  logic        stall3, busy3, done3;
  logic [31:0] hi3, lo3;

  int n_checks = 0;
  int n_errors = 0;

  exec_muldiv #(.WIDTH(32), .MUL_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  exec_muldiv #(.WIDTH(32), .MUL_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush3), .stall(stall3), .busy(busy3), .done(done3), .hi(hi3), .lo(lo3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {hi,lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (o)
      MD_MULT:  res = sa * sb;
      MD_MULTU: res = ua * ub;
      MD_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle, check every cycle until done; returns in the DONE cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int          lat;
    exp = ref_model(o, a, b);
    lat = o[1] ? 34 : 2;
    op = o; src_a = a; src_b = b; start = 1'b1; flush = 1'b0;
    #1;
    check({tag, "_stall_accept"}, {63'd0, stall}, 64'd1);
    tick();
    for (int k = 1; k < lat; k++) begin
      // garbage inputs and stray starts while busy must have no effect
      start = 1'($urandom_range(0, 1));
      op    = 2'($urandom_range(0, 3));
      src_a = $urandom;
      src_b = $urandom;
      #1;
      check({tag, "_busy_phase"}, {61'd0, stall, busy, done}, 64'd6);
      tick();
    end
    start = 1'b0;
    #1;
    check({tag, "_done_flags"}, {61'd0, stall, busy, done}, 64'd1);
    check({tag, "_result"}, {hi, lo}, exp);
  endtask

  initial begin
    logic        seen_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1; start = 1'b0; flush = 1'b0; start3 = 1'b0; flush3 = 1'b0;
    op = 2'b00; src_a = 32'd0; src_b = 32'd0;
    tick(); tick();
    check("reset_state", {hi, lo, 29'd0, stall, busy, done}, 96'd0);
    reset = 1'b0;
    tick();

    // 1: MULTU max x max
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "t1_multu");
    check("t1_const", {hi, lo}, 64'hFFFFFFFE_00000001);

    // 2: MULT -3 x 7, then the MUL_LATENCY=3 instance
    run_op(MD_MULT, 32'hFFFFFFFD, 32'h00000007, "t2_mult");
    check("t2_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    tick();
    op = MD_MULT; src_a = 32'hFFFFFFFD; src_b = 32'h00000007; start3 = 1'b1;
    #1;
    check("t2_lat3_stall_accept", {63'd0, stall3}, 64'd1);
    tick();
    start3 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check("t2_lat3_busy", {61'd0, stall3, busy3, done3}, 64'd6);
      tick();
    end
    check("t2_lat3_done", {61'd0, stall3, busy3, done3}, 64'd1);
    check("t2_lat3_result", {hi3, lo3}, 64'hFFFFFFFF_FFFFFFEB);

    // 3: DIV -7/2, then DIVU 100/7 started in the DONE cycle
    tick();
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, "t3_div");
    check("t3_div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(MD_DIVU, 32'd100, 32'd7, "t3_divu_b2b");
    check("t3_divu_const", {hi, lo}, 64'h00000002_0000000E);

    // 4: divide by zero and the overflow case
    run_op(MD_DIVU, 32'd5, 32'd0, "t4_divu_zero");
    check("t4_divu_zero_const", {hi, lo}, 64'h00000005_FFFFFFFF);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, "t4_div_ovf");
    check("t4_div_ovf_const", {hi, lo}, 64'h00000000_80000000);
    run_op(MD_DIV, 32'hFFFFFFFB, 32'd0, "t4_div_neg_zero");
    check("t4_div_neg_zero_const", {hi, lo}, 64'hFFFFFFFB_FFFFFFFF);

    // 5: flush mid-divide keeps the previous result
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "t5_pre");
    tick();
    op = MD_DIV; src_a = 32'd100; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1; start = 1'b1;
    tick();
    flush = 1'b0; start = 1'b0;
    #1;
    check("t5_after_flush", {61'd0, stall, busy, done}, 64'd0);
    check("t5_hold_result", {hi, lo}, 64'hFFFFFFFE_00000001);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen_done = seen_done | done | busy;
    end
    check("t5_no_done_after_flush", {63'd0, seen_done}, 64'd0);
    // start together with flush is ignored
    start = 1'b1; flush = 1'b1;
    #1;
    check("t5_flush_start_stall", {63'd0, stall}, 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    check("t5_flush_start_idle", {62'd0, busy, done}, 64'd0);
    run_op(MD_MULTU, 32'd2, 32'd3, "t5_multu");
    check("t5_multu_const", {hi, lo}, 64'h00000000_00000006);

    // 6: asynchronous reset during DIV iteration 20
    tick();
    op = MD_DIV; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_reset", {hi, lo, 29'd0, stall, busy, done}, 96'd0);
    start = 1'b1;
    #1;
    check("t6_stall_start_only", {63'd0, stall}, 64'd1);
    start = 1'b0;
    #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen_done = seen_done | done | busy;
    end
    check("t6_no_done_after_reset", {63'd0, seen_done}, 64'd0);

    // randomized ops, mixed back-to-back and idle gaps
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = $urandom_range(1, 16);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
